// File: rtl/chess_board_ctrl.sv
// chess_board_ctrl: board, cursor, selection and turn state for the chess display
module chess_board_ctrl #(
    parameter logic [5:0] CURSOR_INIT = 6'd52,
    parameter bit         PROMOTE_EN  = 1'b1
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         BTN_UP,
    input  logic         BTN_DOWN,
    input  logic         BTN_LEFT,
    input  logic         BTN_RIGHT,
    input  logic         BTN_CENTER,
    output logic [255:0] BOARD,
    output logic [5:0]   CURSOR_ADDR,
    output logic [5:0]   SELECT_ADDR,
    output logic         SELECT_EN,
    output logic         TURN,
    output logic         GAME_OVER,
    output logic         WINNER
);

    // Starting position, row 7 in the top word; col 0 is the lowest nibble of each row
    localparam logic [255:0] INIT_BOARD = {
        32'h42365324, 32'h11111111, 128'h0, 32'h99999999, 32'hCABEDBAC
    };

    typedef enum logic [1:0] {S_IDLE, S_SEL, S_MOVE, S_OVER} state_t;

    state_t       r_state, w_next;
    logic [255:0] r_board, w_board_nx;
    logic [5:0]   r_cursor, w_cursor_nx;
    logic [5:0]   r_sel, w_sel_nx;
    logic [5:0]   r_dest, w_dest_nx;
    logic         r_sel_en, w_sel_en_nx;
    logic         r_turn, w_turn_nx;
    logic         r_over, w_over_nx;
    logic         r_winner, w_winner_nx;

    logic [3:0]   w_cur_piece, w_src_piece, w_dst_piece, w_moved;
    logic         w_own, w_promote, w_nav;

    assign w_cur_piece = r_board[{r_cursor, 2'b00} +: 4];
    assign w_src_piece = r_board[{r_sel, 2'b00} +: 4];
    assign w_dst_piece = r_board[{r_dest, 2'b00} +: 4];
    assign w_own       = (w_cur_piece[2:0] != 3'd0) && (w_cur_piece[3] == r_turn);
    assign w_nav       = (r_state == S_IDLE) || (r_state == S_SEL);
    // A pawn promotes on the rank farthest from its own side
    assign w_promote   = PROMOTE_EN && (w_src_piece[2:0] == 3'd1) &&
                         (w_src_piece[3] ? (r_dest[5:3] == 3'd7) : (r_dest[5:3] == 3'd0));
    assign w_moved     = w_promote ? {w_src_piece[3], 3'd5} : w_src_piece;

    // Next-state, cursor navigation, selection and move execution
    always_comb begin
        w_next      = r_state;
        w_board_nx  = r_board;
        w_cursor_nx = r_cursor;
        w_sel_nx    = r_sel;
        w_dest_nx   = r_dest;
        w_sel_en_nx = r_sel_en;
        w_turn_nx   = r_turn;
        w_over_nx   = r_over;
        w_winner_nx = r_winner;
        if (w_nav) begin
            if (BTN_UP)
                w_cursor_nx = {r_cursor[5:3] - 3'd1, r_cursor[2:0]};
            else if (BTN_DOWN)
                w_cursor_nx = {r_cursor[5:3] + 3'd1, r_cursor[2:0]};
            else if (BTN_LEFT)
                w_cursor_nx = {r_cursor[5:3], r_cursor[2:0] - 3'd1};
            else if (BTN_RIGHT)
                w_cursor_nx = {r_cursor[5:3], r_cursor[2:0] + 3'd1};
        end
        case (r_state)
            S_IDLE: begin
                if (BTN_CENTER && w_own) begin
                    w_sel_nx    = r_cursor;
                    w_sel_en_nx = 1'b1;
                    w_next      = S_SEL;
                end
            end
            S_SEL: begin
                if (BTN_CENTER) begin
                    if (r_cursor == r_sel) begin
                        w_sel_en_nx = 1'b0;
                        w_next      = S_IDLE;
                    end else if (w_own) begin
                        w_sel_nx = r_cursor;
                    end else begin
                        w_dest_nx = r_cursor;
                        w_next    = S_MOVE;
                    end
                end
            end
            S_MOVE: begin
                w_board_nx[{r_dest, 2'b00} +: 4] = w_moved;
                w_board_nx[{r_sel, 2'b00} +: 4]  = 4'h0;
                w_sel_en_nx = 1'b0;
                w_turn_nx   = ~r_turn;
                if (w_dst_piece[2:0] == 3'd6) begin
                    w_over_nx   = 1'b1;
                    w_winner_nx = r_turn;
                    w_next      = S_OVER;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: ;
        endcase
    end

    // Register all game state; reset wins over any move in progress
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state  <= S_IDLE;
            r_board  <= INIT_BOARD;
            r_cursor <= CURSOR_INIT;
            r_sel    <= 6'd0;
            r_dest   <= 6'd0;
            r_sel_en <= 1'b0;
            r_turn   <= 1'b0;
            r_over   <= 1'b0;
            r_winner <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_board  <= w_board_nx;
            r_cursor <= w_cursor_nx;
            r_sel    <= w_sel_nx;
            r_dest   <= w_dest_nx;
            r_sel_en <= w_sel_en_nx;
            r_turn   <= w_turn_nx;
            r_over   <= w_over_nx;
            r_winner <= w_winner_nx;
        end
    end

    assign BOARD       = r_board;
    assign CURSOR_ADDR = r_cursor;
    assign SELECT_ADDR = r_sel;
    assign SELECT_EN   = r_sel_en;
    assign TURN        = r_turn;
    assign GAME_OVER   = r_over;
    assign WINNER      = r_winner;

endmodule

// File: tb/tb_chess_board_ctrl.sv
// tb_chess_board_ctrl: directed game sequences against promoting and non-promoting builds
module tb_chess_board_ctrl;

    localparam logic [255:0] INIT_BOARD = {
        32'h42365324, 32'h11111111, 128'h0, 32'h99999999, 32'hCABEDBAC
    };

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic         bu = 1'b0, bd = 1'b0, bl = 1'b0, br = 1'b0, bc = 1'b0;
    logic [255:0] brd1, brd0;
    logic [5:0]   cur1, cur0, sel1, sel0;
    logic         sen1, sen0, turn1, turn0, ovr1, ovr0, win1, win0;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [5:0]   c;

    chess_board_ctrl #(.CURSOR_INIT(6'd52), .PROMOTE_EN(1'b1)) d1 (
        .CLK(CLK), .RESET(RESET),
        .BTN_UP(bu), .BTN_DOWN(bd), .BTN_LEFT(bl), .BTN_RIGHT(br), .BTN_CENTER(bc),
        .BOARD(brd1), .CURSOR_ADDR(cur1), .SELECT_ADDR(sel1), .SELECT_EN(sen1),
        .TURN(turn1), .GAME_OVER(ovr1), .WINNER(win1)
    );

    chess_board_ctrl #(.CURSOR_INIT(6'd52), .PROMOTE_EN(1'b0)) d0 (
        .CLK(CLK), .RESET(RESET),
        .BTN_UP(bu), .BTN_DOWN(bd), .BTN_LEFT(bl), .BTN_RIGHT(br), .BTN_CENTER(bc),
        .BOARD(brd0), .CURSOR_ADDR(cur0), .SELECT_ADDR(sel0), .SELECT_EN(sen0),
        .TURN(turn0), .GAME_OVER(ovr0), .WINNER(win0)
    );

    always #5 CLK = ~CLK;

    function automatic logic [3:0] sq(input logic [255:0] b, input int i);
        return b[i*4 +: 4];
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one button pattern for exactly one sampling edge; return at the following negedge
    task automatic press(input logic u, input logic d, input logic l, input logic r, input logic ce);
        @(negedge CLK);
        {bu, bd, bl, br, bc} = {u, d, l, r, ce};
        @(negedge CLK);
        {bu, bd, bl, br, bc} = 5'b0;
    endtask

    task automatic goto(input logic [5:0] t);
        while (c[5:3] != t[5:3]) begin
            press(0, 1, 0, 0, 0);
            c[5:3] = c[5:3] + 3'd1;
        end
        while (c[2:0] != t[2:0]) begin
            press(0, 0, 0, 1, 0);
            c[2:0] = c[2:0] + 3'd1;
        end
    endtask

    // Select src, move cursor to dst, commit, and wait for the MOVE cycle to complete
    task automatic play(input logic [5:0] src, input logic [5:0] dst);
        goto(src);
        press(0, 0, 0, 0, 1);
        goto(dst);
        press(0, 0, 0, 0, 1);
        @(negedge CLK);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        c = 6'd52;
        @(negedge CLK);
        check("rst_sq0", sq(brd1, 0), 4'hC);
        check("rst_sq4", sq(brd1, 4), 4'hE);
        check("rst_sq60", sq(brd1, 60), 4'h6);
        check("rst_board", brd1, INIT_BOARD);
        check("rst_cursor", cur1, 6'd52);
        check("rst_turn", turn1, 1'b0);
        check("rst_selen", sen1, 1'b0);
        check("rst_over", ovr1, 1'b0);

        goto(6'd0);
        check("cur_goto0", cur1, 6'd0);
        press(1, 0, 0, 0, 0);
        check("cur_up_wrap", cur1, 6'd56);
        press(0, 0, 1, 0, 0);
        check("cur_left_wrap", cur1, 6'd63);
        press(1, 0, 0, 1, 0);
        check("cur_up_right", cur1, 6'd55);
        press(0, 1, 1, 0, 0);
        check("cur_down_left", cur1, 6'd63);
        c = 6'd63;

        goto(6'd12);
        press(0, 0, 0, 0, 1);
        check("wrong_colour", sen1, 1'b0);
        goto(6'd28);
        press(0, 0, 0, 0, 1);
        check("empty_idle_sel", sen1, 1'b0);
        check("empty_idle_board", brd1, INIT_BOARD);

        goto(6'd52);
        press(0, 0, 0, 0, 1);
        check("e2_selen", sen1, 1'b1);
        check("e2_seladdr", sel1, 6'd52);
        goto(6'd36);
        press(0, 0, 0, 0, 1);
        check("lat_sq52_held", sq(brd1, 52), 4'h1);
        check("lat_turn_held", turn1, 1'b0);
        @(negedge CLK);
        check("e4_sq36", sq(brd1, 36), 4'h1);
        check("e4_sq52", sq(brd1, 52), 4'h0);
        check("e4_turn", turn1, 1'b1);
        check("e4_selen", sen1, 1'b0);

        play(6'd11, 6'd19);
        check("blk_sq19", sq(brd1, 19), 4'h9);
        check("blk_turn", turn1, 1'b0);

        goto(6'd53);
        press(0, 0, 0, 0, 1);
        goto(6'd54);
        press(0, 0, 0, 0, 1);
        check("reselect_addr", sel1, 6'd54);
        check("reselect_en", sen1, 1'b1);
        press(0, 0, 0, 0, 1);
        check("deselect_en", sen1, 1'b0);
        press(0, 0, 1, 0, 1);
        check("ctr_dir_sel", sel1, 6'd54);
        check("ctr_dir_cur", cur1, 6'd53);
        c = 6'd53;
        press(0, 0, 0, 0, 1);
        check("reselect2", sel1, 6'd53);
        press(0, 0, 0, 0, 1);
        check("deselect2", sen1, 1'b0);

        play(6'd48, 6'd8);
        check("cap_sq8", sq(brd1, 8), 4'h1);
        check("cap_sq48", sq(brd1, 48), 4'h0);
        play(6'd9, 6'd17);
        play(6'd8, 6'd0);
        check("promo_on", sq(brd1, 0), 4'h5);
        check("promo_off", sq(brd0, 0), 4'h1);
        check("promo_src", sq(brd1, 8), 4'h0);
        check("promo_turn", turn1, 1'b1);
        play(6'd17, 6'd25);
        play(6'd0, 6'd4);
        check("king_over1", ovr1, 1'b1);
        check("king_over0", ovr0, 1'b1);
        check("king_winner", win1, 1'b0);
        check("king_sq4_q", sq(brd1, 4), 4'h5);
        check("king_sq4_p", sq(brd0, 4), 4'h1);
        press(1, 0, 0, 0, 1);
        press(0, 0, 0, 1, 0);
        check("over_cursor", cur1, 6'd4);
        check("over_sq4", sq(brd1, 4), 4'h5);
        check("over_sq0", sq(brd1, 0), 4'h0);
        check("over_turn", turn1, 1'b1);
        check("over_hold", ovr1, 1'b1);

        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        c = 6'd52;
        goto(6'd51);
        press(0, 0, 0, 0, 1);
        goto(6'd35);
        press(0, 0, 0, 0, 1);
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check("midmove_board", brd1, INIT_BOARD);
        check("midmove_turn", turn1, 1'b0);
        check("midmove_selen", sen1, 1'b0);
        check("midmove_cursor", cur1, 6'd52);
        check("midmove_over", ovr1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
